sync_updown_counter_n: RTL and testbench

SYNC_UPDOWN_COUNTER_N -- requirements
Module: sync_updown_counter_n

---
 rtl/sync_updown_counter_n_if.sv | 25 ++
 rtl/sync_updown_counter_n.sv | 98 +++++++++
 tb/tb_sync_updown_counter_n.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_updown_counter_n_if.sv
// Control and status bundle for sync_updown_counter_n.
// Every control is sampled on the rising edge of clk with no valid/ready handshake; Q, wrap and ovf are registered, tc is combinational.
interface sync_updown_counter_n_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up_dn;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output clear, load, load_val, en, up_dn,
        input  Q, tc, wrap, ovf
    );

    modport slave (
        input  clear, load, load_val, en, up_dn,
        output Q, tc, wrap, ovf
    );
endinterface

// File: rtl/sync_updown_counter_n.sv
// Up/down counter over 0..MAX with clear > load > count priority.
// At a limit it either wraps (one-cycle wrap pulse) or saturates; ovf latches any limit hit until clear/reset.
module sync_updown_counter_n #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 15,
    parameter int SATURATE = 0
) (
    input logic                    clk,
    input logic                    reset_n,
    sync_updown_counter_n_if.slave bus
);
    generate
        if (WIDTH < 2 || MAX < 1 || MAX > (2 ** WIDTH) - 1) begin : g_bad_params
            $error("sync_updown_counter_n: illegal WIDTH/MAX combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_STEP,
        OP_LIMIT
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_r;
    logic             wrap_nxt;
    logic             ovf_r;
    logic             ovf_nxt;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q_r == MAX_V);
    assign at_zero = (q_r == '0);

    // Decode the single action this edge will take; priority lives here only.
    always_comb begin
        op = OP_HOLD;
        if (bus.clear) begin
            op = OP_CLEAR;
        end else if (bus.load) begin
            op = OP_LOAD;
        end else if (bus.en) begin
            op = (bus.up_dn ? at_max : at_zero) ? OP_LIMIT : OP_STEP;
        end
    end

    always_comb begin
        q_nxt    = q_r;
        wrap_nxt = 1'b0;
        ovf_nxt  = ovf_r;
        unique case (op)
            OP_CLEAR: begin
                q_nxt   = '0;
                ovf_nxt = 1'b0;
            end
            OP_LOAD: begin
                q_nxt = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
            end
            OP_STEP: begin
                q_nxt = bus.up_dn ? (q_r + ONE) : (q_r - ONE);
            end
            OP_LIMIT: begin
                ovf_nxt = 1'b1;
                if (SATURATE == 0) begin
                    q_nxt    = bus.up_dn ? '0 : MAX_V;
                    wrap_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            wrap_r <= wrap_nxt;
            ovf_r  <= ovf_nxt;
        end
    end

    // tc looks at the current count and controls, so it flags the edge about to hit a limit.
    assign bus.tc   = bus.en & ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));
    assign bus.Q    = q_r;
    assign bus.wrap = wrap_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_sync_updown_counter_n.sv
// Bench for sync_updown_counter_n: three instances (MAX=9 wrap, MAX=9 saturate, MAX=15 wrap) share one stimulus stream.
// Directed scenarios use fixed expectations; the random phase compares against an arithmetic reference model.
module tb_sync_updown_counter_n;
    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up_dn;

    int checks;
    int failures;

    sync_updown_counter_n_if #(.WIDTH(4)) if_a ();
    sync_updown_counter_n_if #(.WIDTH(4)) if_s ();
    sync_updown_counter_n_if #(.WIDTH(4)) if_f ();

    assign if_a.clear = clear;  assign if_a.load = load;  assign if_a.load_val = load_val;
    assign if_a.en    = en;     assign if_a.up_dn = up_dn;
    assign if_s.clear = clear;  assign if_s.load = load;  assign if_s.load_val = load_val;
    assign if_s.en    = en;     assign if_s.up_dn = up_dn;
    assign if_f.clear = clear;  assign if_f.load = load;  assign if_f.load_val = load_val;
    assign if_f.en    = en;     assign if_f.up_dn = up_dn;

    sync_updown_counter_n #(.WIDTH(4), .MAX(9),  .SATURATE(0)) dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
    sync_updown_counter_n #(.WIDTH(4), .MAX(9),  .SATURATE(1)) dut_s (.clk(clk), .reset_n(reset_n), .bus(if_s));
    sync_updown_counter_n #(.WIDTH(4), .MAX(15), .SATURATE(0)) dut_f (.clk(clk), .reset_n(reset_n), .bus(if_f));

    logic [3:0] obs_q    [3];
    logic       obs_tc   [3];
    logic       obs_wrap [3];
    logic       obs_ovf  [3];
    assign obs_q[0] = if_a.Q;  assign obs_tc[0] = if_a.tc;  assign obs_wrap[0] = if_a.wrap;  assign obs_ovf[0] = if_a.ovf;
    assign obs_q[1] = if_s.Q;  assign obs_tc[1] = if_s.tc;  assign obs_wrap[1] = if_s.wrap;  assign obs_ovf[1] = if_s.ovf;
    assign obs_q[2] = if_f.Q;  assign obs_tc[2] = if_f.tc;  assign obs_wrap[2] = if_f.wrap;  assign obs_ovf[2] = if_f.ovf;

    // Reference model: one integer count plus flags per instance.
    int m_max [3] = '{9, 9, 15};
    int m_sat [3] = '{0, 1, 0};
    int m_q   [3];
    int m_wrap[3];
    int m_ovf [3];

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic model_tc(int i);
        return en && ((up_dn && m_q[i] == m_max[i]) || (!up_dn && m_q[i] == 0));
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 3; i++) begin
            m_q[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
        end
    endtask

    // Advance one rising edge with the current inputs, then settle 1 time unit past it.
    task automatic tick();
        int nq[3];
        int nw[3];
        int no[3];
        for (int i = 0; i < 3; i++) begin
            nq[i] = m_q[i]; nw[i] = 0; no[i] = m_ovf[i];
            if (clear) begin
                nq[i] = 0; no[i] = 0;
            end else if (load) begin
                nq[i] = (int'(load_val) > m_max[i]) ? m_max[i] : int'(load_val);
            end else if (en) begin
                if (up_dn && m_q[i] < m_max[i]) nq[i] = m_q[i] + 1;
                else if (!up_dn && m_q[i] > 0) nq[i] = m_q[i] - 1;
                else begin
                    no[i] = 1;
                    if (m_sat[i] == 0) begin
                        nq[i] = up_dn ? 0 : m_max[i];
                        nw[i] = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            m_q[i] = nq[i]; m_wrap[i] = nw[i]; m_ovf[i] = no[i];
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_zero();
        reset_n = 1'b1;
    endtask

    task automatic set_in(input logic c, input logic l, input logic [3:0] lv, input logic e, input logic u);
        clear = c; load = l; load_val = lv; en = e; up_dn = u;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i] !== 4'd0 || obs_wrap[i] !== 1'b0 || obs_ovf[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_async[%0d]: got q=%0d wrap=%b ovf=%b required q=0 wrap=0 ovf=0",
                         i, obs_q[i], obs_wrap[i], obs_ovf[i]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (if_a.Q !== 4'd0) begin
            failures++;
            $display("FAIL reset_held: got q=%0d required 0", if_a.Q);
        end
        model_zero();
        reset_n = 1'b1;
    endtask

    task automatic test_count_up();
        logic [3:0] exp_q[$];
        int prev;
        int seen_wrap;
        do_reset();
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        for (int v = 1; v <= 9; v++) exp_q.push_back(4'(v));
        exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2);
        prev = 0;
        seen_wrap = 0;
        for (int n = 0; n < 12; n++) begin
            logic [3:0] e;
            #1;
            checks++;
            if (if_a.tc !== (prev == 9)) begin
                failures++;
                $display("FAIL up_tc edge %0d: got %b required %b", n, if_a.tc, (prev == 9));
            end
            tick();
            e = exp_q.pop_front();
            if (prev == 9) seen_wrap = 1;
            checks++;
            if (if_a.Q !== e || if_a.wrap !== (prev == 9) || if_a.ovf !== 1'(seen_wrap)) begin
                failures++;
                $display("FAIL up_seq edge %0d: got q=%0d wrap=%b ovf=%b required q=%0d wrap=%b ovf=%0d",
                         n, if_a.Q, if_a.wrap, if_a.ovf, e, (prev == 9), seen_wrap);
            end
            prev = int'(e);
        end
    endtask

    task automatic test_count_down();
        logic [3:0] exp_q[$] = '{4'd9, 4'd8, 4'd7};
        do_reset();
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        #1;
        checks++;
        if (if_a.tc !== 1'b1) begin
            failures++;
            $display("FAIL down_tc_at_zero: got %b required 1", if_a.tc);
        end
        for (int n = 0; n < 3; n++) begin
            logic [3:0] e;
            tick();
            e = exp_q.pop_front();
            checks++;
            if (if_a.Q !== e || if_a.wrap !== (n == 0) || if_a.ovf !== 1'b1) begin
                failures++;
                $display("FAIL down_seq edge %0d: got q=%0d wrap=%b ovf=%b required q=%0d wrap=%b ovf=1",
                         n, if_a.Q, if_a.wrap, if_a.ovf, e, (n == 0));
            end
        end
    endtask

    task automatic test_load_clear();
        do_reset();
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 4'd13, 1'b1, 1'b1);
        tick();
        checks++;
        if (if_a.Q !== 4'd9 || if_s.Q !== 4'd9 || if_f.Q !== 4'd13) begin
            failures++;
            $display("FAIL load_clamp: got a=%0d s=%0d f=%0d required a=9 s=9 f=13", if_a.Q, if_s.Q, if_f.Q);
        end
        checks++;
        if (if_a.wrap !== 1'b0 || if_a.ovf !== 1'b1) begin
            failures++;
            $display("FAIL load_flags: got wrap=%b ovf=%b required wrap=0 ovf=1", if_a.wrap, if_a.ovf);
        end
        set_in(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i] !== 4'd0 || obs_ovf[i] !== 1'b0 || obs_wrap[i] !== 1'b0) begin
                failures++;
                $display("FAIL clear_over_load[%0d]: got q=%0d ovf=%b wrap=%b required 0 0 0",
                         i, obs_q[i], obs_ovf[i], obs_wrap[i]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_q[$] = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
        do_reset();
        set_in(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        for (int n = 0; n < 5; n++) begin
            logic [3:0] e;
            tick();
            e = exp_q.pop_front();
            checks++;
            if (if_s.Q !== e || if_s.wrap !== 1'b0 || if_s.ovf !== (n >= 2)) begin
                failures++;
                $display("FAIL sat_up edge %0d: got q=%0d wrap=%b ovf=%b required q=%0d wrap=0 ovf=%b",
                         n, if_s.Q, if_s.wrap, if_s.ovf, e, (n >= 2));
            end
        end
        set_in(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        #1;
        checks++;
        if (if_s.tc !== 1'b1) begin
            failures++;
            $display("FAIL sat_tc_zero: got %b required 1", if_s.tc);
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (if_s.Q !== 4'd0 || if_s.wrap !== 1'b0) begin
                failures++;
                $display("FAIL sat_down edge %0d: got q=%0d wrap=%b required q=0 wrap=0", n, if_s.Q, if_s.wrap);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(1'b0, 1'b1, 4'd4, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (if_a.Q !== 4'd0 || if_a.wrap !== 1'b0 || if_a.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got q=%0d wrap=%b ovf=%b required 0 0 0", if_a.Q, if_a.wrap, if_a.ovf);
        end
        model_zero();
        #1;
        reset_n = 1'b1;
        tick();
        checks++;
        if (if_a.Q !== 4'd1) begin
            failures++;
            $display("FAIL reset_release_first_edge: got q=%0d required 1", if_a.Q);
        end
    endtask

    task automatic test_full_range();
        logic [3:0] exp_q[$] = '{4'd8, 4'd7, 4'd8, 4'd7};
        do_reset();
        set_in(1'b0, 1'b1, 4'd15, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        checks++;
        if (if_f.Q !== 4'd0 || if_f.wrap !== 1'b1 || if_f.ovf !== 1'b1) begin
            failures++;
            $display("FAIL full_wrap: got q=%0d wrap=%b ovf=%b required q=0 wrap=1 ovf=1", if_f.Q, if_f.wrap, if_f.ovf);
        end
        tick();
        checks++;
        if (if_f.Q !== 4'd1 || if_f.wrap !== 1'b0) begin
            failures++;
            $display("FAIL full_wrap_pulse_end: got q=%0d wrap=%b required q=1 wrap=0", if_f.Q, if_f.wrap);
        end
        set_in(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
        tick();
        for (int n = 0; n < 4; n++) begin
            logic [3:0] e;
            set_in(1'b0, 1'b0, 4'd0, 1'b1, (n % 2) == 0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (if_f.Q !== e) begin
                failures++;
                $display("FAIL toggle_dir edge %0d: got q=%0d required %0d", n, if_f.Q, e);
            end
        end
    endtask

    task automatic test_random();
        logic dir;
        dir = 1'b1;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            set_in($urandom_range(0, 99) < 3, $urandom_range(0, 11) == 0, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3) != 0, dir);
            if ($urandom_range(0, 149) == 0) do_reset();
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_tc[i] !== model_tc(i)) begin
                    failures++;
                    $display("FAIL rand_tc[%0d] cycle %0d: got %b required %b", i, n, obs_tc[i], model_tc(i));
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (int'(obs_q[i]) != m_q[i] || obs_wrap[i] !== 1'(m_wrap[i]) || obs_ovf[i] !== 1'(m_ovf[i])) begin
                    failures++;
                    $display("FAIL rand_state[%0d] cycle %0d: got q=%0d wrap=%b ovf=%b required q=%0d wrap=%0d ovf=%0d",
                             i, n, obs_q[i], obs_wrap[i], obs_ovf[i], m_q[i], m_wrap[i], m_ovf[i]);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b1;
        set_in(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        model_zero();
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clear();
        test_saturate();
        test_reset_mid();
        test_full_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
